// File: rtl/seg7_scan_display.sv
// Converts a 14-bit binary value to BCD with a sequential double-dabble engine and
// scans it onto a 4-digit multiplexed 7-segment display. Optional macro: SEG7_BLANK_LZ_EN.
module seg7_scan_display #(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic [13:0] value_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic [15:0] bcd_o,
    output logic        ovf_o,
    output logic        busy_o
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Add 3 to every nibble that is 5 or more before the next shift.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 5; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = s[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Active-high {g,f,e,d,c,b,a} pattern; codes 10..15 show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

`ifdef SEG7_BLANK_LZ_EN
    // A digit is a leading zero when it and every more significant digit are zero.
    function automatic logic leading_zero(input logic [15:0] b, input logic [1:0] idx);
        logic z;
        case (idx)
            2'd1:    z = (b[15:4] == 12'h000);
            2'd2:    z = (b[15:8] == 8'h00);
            2'd3:    z = (b[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [13:0]     shift_q, shift_d;
    logic [19:0]     scratch_q, scratch_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic [RW-1:0]   rc_q, rc_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [19:0]     adj_s;
    logic [3:0]      nib_s;
    logic            blank_s;
    logic [6:0]      pat_s;

    assign adj_s = dabble_adjust(scratch_q);

    // Conversion FSM next state and datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                shift_d   = value_i;
                scratch_d = 20'h00000;
                cnt_d     = 4'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                {scratch_d, shift_d} = {adj_s, shift_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q[15:0];
                ovf_d   = (scratch_q[19:16] != 4'h0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Scan counter, digit select and segment/anode drive, all from next-state values
    // so a digit switch coinciding with a result update shows the new result.
    always_comb begin
        rc_d  = rc_q;
        idx_d = idx_q;
        if (rc_q == RC_LAST) begin
            rc_d  = {RW{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            rc_d  = rc_q + RW'(1);
            idx_d = idx_q;
        end

        case (idx_d)
            2'd0:    nib_s = bcd_d[3:0];
            2'd1:    nib_s = bcd_d[7:4];
            2'd2:    nib_s = bcd_d[11:8];
            2'd3:    nib_s = bcd_d[15:12];
            default: nib_s = 4'h0;
        endcase

`ifdef SEG7_BLANK_LZ_EN
        blank_s = leading_zero(bcd_d, idx_d);
`else
        blank_s = 1'b0;
`endif

        if (ovf_d) begin
            pat_s = 7'h40;
        end else if (blank_s) begin
            pat_s = 7'h00;
        end else begin
            pat_s = seg_decode(nib_s);
        end

        seg_d = SEG_ACTIVE_LOW ? ~pat_s : pat_s;
        an_d  = AN_ACTIVE_LOW ? ~(4'b0001 << idx_d) : (4'b0001 << idx_d);
        dp_d  = DP_OFF;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 14'h0000;
            scratch_q <= 20'h00000;
            bcd_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            rc_q      <= {RW{1'b0}};
            idx_q     <= 2'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            rc_q      <= rc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign seg_o  = seg_q;
    assign dp_o   = dp_q;
    assign an_o   = an_q;
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: expected conversions are queued when the value is
// sampled and compared when the result is due; scan outputs are checked every cycle.
module tb_seg7_scan_display;

    logic        clock = 1'b0;
    logic        reset_i;
    logic [13:0] value_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic [15:0] bcd_o;
    logic        ovf_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          rc  = 0;
    int          idx = 0;
    logic        in_reset = 1'b1;
    logic        started  = 1'b0;
    logic [16:0] exp_q[$];
    logic [15:0] cur_bcd = 16'h0000;
    logic        cur_ovf = 1'b0;
    logic [16:0] popped;

    seg7_scan_display #(
        .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset_i(reset_i),
        .value_i(value_i),
        .seg_o(seg_o),
        .dp_o(dp_o),
        .an_o(an_o),
        .bcd_o(bcd_o),
        .ovf_o(ovf_o),
        .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model_conv(input int v);
        int m;
        logic [15:0] b;
        m = v % 10000;
        b = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        return {(v > 9999), b};
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] b, input logic o, input int d);
        logic [6:0] tbl [0:9];
        logic [3:0] n;
        logic       blank;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        n = b[d*4 +: 4];
        blank = 1'b0;
`ifdef SEG7_BLANK_LZ_EN
        if (d == 3) blank = (b[15:12] == 4'h0);
        else if (d == 2) blank = (b[15:8] == 8'h00);
        else if (d == 1) blank = (b[15:4] == 12'h000);
`endif
        if (o) return ~7'h40;
        if (blank) return 7'h7F;
        if (n > 4'd9) return 7'h7F;
        return ~tbl[n];
    endfunction

    // Reference model advances on each edge, then outputs are compared just after it.
    always @(posedge clock) begin
        if (reset_i) begin
            in_reset = 1'b1;
            started  = 1'b1;
            cyc = 0;
            rc  = 0;
            idx = 0;
            exp_q.delete();
            cur_bcd = 16'h0000;
            cur_ovf = 1'b0;
        end else begin
            in_reset = 1'b0;
            cyc++;
            if (cyc % 16 == 1) exp_q.push_back(model_conv(int'(value_i)));
            if (cyc % 16 == 0) begin
                if (exp_q.size() == 0) begin
                    check_val("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    popped  = exp_q.pop_front();
                    cur_bcd = popped[15:0];
                    cur_ovf = popped[16];
                end
            end
            if (rc == 3) begin
                rc  = 0;
                idx = (idx + 1) % 4;
            end else begin
                rc++;
            end
        end
        #1;
        if (started) begin
            check_val("bcd", 32'(bcd_o), 32'(cur_bcd));
            check_val("ovf", 32'(ovf_o), 32'(cur_ovf));
            check_val("dp", 32'(dp_o), 32'd1);
            if (in_reset) begin
                check_val("an_rst", 32'(an_o), 32'hF);
                check_val("seg_rst", 32'(seg_o), 32'h7F);
                check_val("busy_rst", 32'(busy_o), 32'd0);
            end else begin
                check_val("an", 32'(an_o), 32'(~(4'b0001 << idx) & 4'hF));
                check_val("seg", 32'(seg_o), 32'(model_seg(cur_bcd, cur_ovf, idx)));
                check_val("busy", 32'(busy_o), 32'((cyc % 16) != 0));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_phase(input int k);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cyc % 16 == k) break;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        value_i = 14'd0;
        run(3);
        value_i = 14'd1234;
        reset_i = 1'b0;
        run(48);
        value_i = 14'd9999;
        run(40);
        value_i = 14'd10000;
        run(40);
        value_i = 14'd16383;
        run(40);
        value_i = 14'd5;
        wait_phase(1);
        wait_phase(3);
        value_i = 14'd300;
        run(40);
        value_i = 14'd777;
        wait_phase(1);
        wait_phase(5);
        reset_i = 1'b1;
        run(2);
        reset_i = 1'b0;
        run(40);
        value_i = 14'd0;
        run(40);
        value_i = 14'd42;
        run(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
